// File: rtl/tcp_vlg_rtx_ctl_if.sv
// Retransmit request handshake between the
// retransmission controller and the TX engine.
interface tcp_vlg_rtx_ctl_if;
    logic        rtx_req;
    logic [31:0] rtx_seq;
    logic        rtx_fast;
    logic        rtx_ack;

    modport master (
        output rtx_req,
        output rtx_seq,
        output rtx_fast,
        input  rtx_ack
    );

    modport slave (
        input  rtx_req,
        input  rtx_seq,
        input  rtx_fast,
        output rtx_ack
    );
endinterface

// File: rtl/tcp_vlg_rtx_ctl.sv
// TCP retransmission controller: RTO timer with
// exponential backoff, fast-retransmit sequencing, abort.
module tcp_vlg_rtx_ctl #(
    parameter int unsigned RTO_TICKS   = 1000000,
    parameter int unsigned MAX_BACKOFF = 6,
    parameter int unsigned MAX_RETRIES = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      connected,
    input  logic [31:0]               loc_seq,
    input  logic [31:0]               rem_ack,
    input  logic                      dup_det,
    input  logic [31:0]               dup_ack,
    tcp_vlg_rtx_ctl_if.master         rtx,
    output logic [3:0]                backoff,
    output logic                      abort
);

    localparam int RW = $clog2(MAX_RETRIES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        REQ,
        DEAD
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   timer_q, timer_d;
    logic [31:0]   seq_q, seq_d;
    logic          fast_q, fast_d;
    logic          lock_q, lock_d;
    logic [3:0]    backoff_q, backoff_d;
    logic [RW-1:0] retries_q, retries_d;
    logic          abort_q, abort_d;
    logic [31:0]   rem_ack_q;
    logic          dup_q;

    logic          outstanding;
    logic          ack_adv;
    logic          dup_rise;
    logic [63:0]   thr_wide;
    logic [31:0]   thr;
    logic          timeout;
    logic [3:0]    backoff_inc;

    assign outstanding = (loc_seq != rem_ack);
    assign ack_adv     = (rem_ack != rem_ack_q);
    assign dup_rise    = dup_det & ~dup_q;

    // Scaled timeout, saturated to 32 bits.
    assign thr_wide = 64'(RTO_TICKS) << backoff_q;
    assign thr      = (|thr_wide[63:32]) ? '1 : thr_wide[31:0];
    assign timeout  = (timer_q == thr - 32'd1);

    assign backoff_inc = (backoff_q >= 4'(MAX_BACKOFF)) ?
                         4'(MAX_BACKOFF) : backoff_q + 4'd1;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            seq_q     <= '0;
            fast_q    <= 1'b0;
            lock_q    <= 1'b0;
            backoff_q <= '0;
            retries_q <= '0;
            abort_q   <= 1'b0;
            rem_ack_q <= '0;
            dup_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            seq_q     <= seq_d;
            fast_q    <= fast_d;
            lock_q    <= lock_d;
            backoff_q <= backoff_d;
            retries_q <= retries_d;
            abort_q   <= abort_d;
            rem_ack_q <= rem_ack;
            dup_q     <= dup_det;
        end
    end

    // Next-state: timer, backoff, request sequencing.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        seq_d     = seq_q;
        fast_d    = fast_q;
        lock_d    = lock_q;
        backoff_d = backoff_q;
        retries_d = retries_q;
        abort_d   = 1'b0;

        if (!connected) begin
            state_d   = IDLE;
            timer_d   = '0;
            backoff_d = '0;
            retries_d = '0;
            lock_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (outstanding) begin
                        state_d = ARMED;
                        timer_d = '0;
                    end
                end
                ARMED: begin
                    if (ack_adv) begin
                        timer_d   = '0;
                        backoff_d = '0;
                        retries_d = '0;
                        lock_d    = 1'b0;
                        if (!outstanding)
                            state_d = IDLE;
                    end else if (!outstanding) begin
                        state_d = IDLE;
                    end else if (timeout) begin
                        if (dup_rise)
                            lock_d = 1'b1;
                        if (retries_q == RW'(MAX_RETRIES)) begin
                            state_d = DEAD;
                            abort_d = 1'b1;
                        end else begin
                            state_d   = REQ;
                            seq_d     = rem_ack;
                            fast_d    = 1'b0;
                            backoff_d = backoff_inc;
                            retries_d = retries_q + RW'(1);
                        end
                    end else if (dup_rise && !lock_q) begin
                        state_d = REQ;
                        seq_d   = dup_ack;
                        fast_d  = 1'b1;
                        lock_d  = 1'b1;
                    end else begin
                        timer_d = timer_q + 32'd1;
                    end
                end
                REQ: begin
                    // Progress resets the backoff but the
                    // pending request is still delivered.
                    if (ack_adv) begin
                        timer_d   = '0;
                        backoff_d = '0;
                        retries_d = '0;
                        lock_d    = 1'b0;
                    end
                    if (rtx.rtx_ack) begin
                        timer_d = '0;
                        state_d = outstanding ? ARMED : IDLE;
                    end
                end
                DEAD: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign rtx.rtx_req  = (state_q == REQ);
    assign rtx.rtx_seq  = (state_q == REQ) ? seq_q : '0;
    assign rtx.rtx_fast = (state_q == REQ) & fast_q;
    assign backoff      = backoff_q;
    assign abort        = abort_q;

endmodule

// File: tb/tb_tcp_vlg_rtx_ctl.sv
// Bench for tcp_vlg_rtx_ctl: deadline-based reference
// model checked every cycle plus directed literal checks.
module tb_tcp_vlg_rtx_ctl;

    localparam int RTO = 16;
    localparam int MB  = 2;
    localparam int MR  = 3;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_PEND = 2;
    localparam int M_DEAD = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        connected = 1'b0;
    logic [31:0] loc_seq = '0;
    logic [31:0] rem_ack = '0;
    logic        dup_det = 1'b0;
    logic [31:0] dup_ack = '0;
    logic [3:0]  backoff;
    logic        abort;

    int errs = 0;
    int checks = 0;

    tcp_vlg_rtx_ctl_if bus ();

    tcp_vlg_rtx_ctl #(
        .RTO_TICKS  (RTO),
        .MAX_BACKOFF(MB),
        .MAX_RETRIES(MR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .connected(connected),
        .loc_seq  (loc_seq),
        .rem_ack  (rem_ack),
        .dup_det  (dup_det),
        .dup_ack  (dup_ack),
        .rtx      (bus.master),
        .backoff  (backoff),
        .abort    (abort)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the retransmit deadline is an
    // absolute edge number rather than a running counter.
    bit      started = 0;
    longint  pcnt = 0;
    longint  deadline = 0;
    int      m_mode = M_IDLE;
    int      m_bo = 0;
    int      m_rt = 0;
    bit      m_lock = 0;
    logic [31:0] m_seq = '0;
    bit      m_fast = 0;
    bit      m_abort = 0;
    logic [31:0] prev_rem = '0;
    bit      prev_dup = 0;

    function automatic longint rto_of(int b);
        longint t;
        t = longint'(RTO) << b;
        if (t > 64'hFFFF_FFFF)
            t = 64'hFFFF_FFFF;
        return t;
    endfunction

    always @(posedge clk) begin
        bit outst, adv, rise;
        started = 1;
        outst = (loc_seq != rem_ack);
        adv   = (rem_ack != prev_rem);
        rise  = dup_det && !prev_dup;
        m_abort = 0;
        if (rst) begin
            m_mode = M_IDLE; m_bo = 0; m_rt = 0; m_lock = 0;
            prev_rem = '0; prev_dup = 0;
        end else begin
            if (!connected) begin
                m_mode = M_IDLE; m_bo = 0; m_rt = 0; m_lock = 0;
            end else begin
                case (m_mode)
                    M_IDLE: if (outst) begin
                        m_mode = M_WAIT;
                        deadline = pcnt + rto_of(m_bo);
                    end
                    M_WAIT: begin
                        if (adv) begin
                            m_bo = 0; m_rt = 0; m_lock = 0;
                            if (!outst) m_mode = M_IDLE;
                            else deadline = pcnt + rto_of(0);
                        end else if (!outst) begin
                            m_mode = M_IDLE;
                        end else if (pcnt == deadline) begin
                            if (rise) m_lock = 1;
                            if (m_rt == MR) begin
                                m_mode = M_DEAD; m_abort = 1;
                            end else begin
                                m_mode = M_PEND; m_seq = rem_ack; m_fast = 0;
                                m_bo = (m_bo + 1 > MB) ? MB : m_bo + 1;
                                m_rt++;
                            end
                        end else if (rise && !m_lock) begin
                            m_mode = M_PEND; m_seq = dup_ack;
                            m_fast = 1; m_lock = 1;
                        end
                    end
                    M_PEND: begin
                        if (adv) begin
                            m_bo = 0; m_rt = 0; m_lock = 0;
                        end
                        if (bus.rtx_ack) begin
                            if (outst) begin
                                m_mode = M_WAIT;
                                deadline = pcnt + rto_of(m_bo);
                            end else begin
                                m_mode = M_IDLE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            prev_rem = rem_ack;
            prev_dup = dup_det;
        end
        pcnt++;
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("req", bus.rtx_req, (m_mode == M_PEND));
            chk("seq", bus.rtx_seq, (m_mode == M_PEND) ? m_seq : 32'd0);
            chk("fast", bus.rtx_fast, (m_mode == M_PEND) && m_fast);
            chk("backoff", backoff, m_bo);
            chk("abort", abort, m_abort);
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; connected = 0; dup_det = 0; bus.rtx_ack = 0;
        loc_seq = 0; rem_ack = 0; dup_ack = 0;
        @(negedge clk);
        chk("rst_req", bus.rtx_req, 0);
        chk("rst_seq", bus.rtx_seq, 0);
        chk("rst_fast", bus.rtx_fast, 0);
        chk("rst_backoff", backoff, 0);
        chk("rst_abort", abort, 0);
        @(negedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        int reqk[$];
        int reqb[$];
        int abk;
        int cnt;
        int firstk;
        logic [31:0] firsts;
        bit found;

        bus.rtx_ack = 0;
        #1;
        // 1: repeated timeouts with backoff, then abort
        do_reset();
        connected = 1; loc_seq = 100; rem_ack = 50; bus.rtx_ack = 1;
        abk = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (bus.rtx_req) begin
                reqk.push_back(k);
                reqb.push_back(int'(backoff));
                chk("t1_seq", bus.rtx_seq, 50);
                chk("t1_fast", bus.rtx_fast, 0);
            end
            if (abort) abk = k;
            #1;
        end
        chk("t1_nreq", reqk.size(), 3);
        if (reqk.size() == 3) begin
            chk("t1_k0", reqk[0], 17);
            chk("t1_k1", reqk[1], 50);
            chk("t1_k2", reqk[2], 115);
            chk("t1_b0", reqb[0], 1);
            chk("t1_b1", reqb[1], 2);
            chk("t1_b2", reqb[2], 2);
        end
        chk("t1_abort_k", abk, 180);
        step(10);
        connected = 0;
        step(2);
        chk("t1_disc_backoff", backoff, 0);

        // 2: fast retransmit held until ack, lock
        connected = 1; loc_seq = 100; rem_ack = 50;
        bus.rtx_ack = 0; dup_det = 0;
        step(3);
        dup_det = 1; dup_ack = 70;
        cnt = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (bus.rtx_req) begin
                cnt++;
                chk("t2_seq", bus.rtx_seq, 70);
                chk("t2_fast", bus.rtx_fast, 1);
            end
            #1;
            bus.rtx_ack = (k == 3);
        end
        chk("t2_held", cnt, 3);
        dup_det = 0;
        step(1);
        dup_det = 1;
        cnt = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (bus.rtx_req) cnt++;
            #1;
        end
        chk("t2_locked", cnt, 0);
        dup_det = 0; rem_ack = 60;
        step(1);
        dup_det = 1; dup_ack = 90; bus.rtx_ack = 1;
        @(negedge clk);
        chk("t2_unlock_req", bus.rtx_req, 1);
        chk("t2_unlock_seq", bus.rtx_seq, 90);
        #1;
        dup_det = 0;
        step(2);

        // 3: ack advance resets backoff
        do_reset();
        connected = 1; loc_seq = 100; rem_ack = 50; bus.rtx_ack = 1;
        step(53);
        chk("t3_bo2", backoff, 2);
        rem_ack = 80;
        firstk = 0; firsts = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) chk("t3_bo0", backoff, 0);
            if (bus.rtx_req && firstk == 0) begin
                firstk = k;
                firsts = bus.rtx_seq;
            end
            #1;
        end
        chk("t3_k", firstk, 17);
        chk("t3_seq", firsts, 80);

        // 4: timeout and dup edge together
        do_reset();
        connected = 1; loc_seq = 100; rem_ack = 50; bus.rtx_ack = 0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 17) begin
                chk("t4_req", bus.rtx_req, 1);
                chk("t4_fast", bus.rtx_fast, 0);
                chk("t4_seq", bus.rtx_seq, 50);
            end
            #1;
            if (k == 16) dup_det = 1;
        end
        bus.rtx_ack = 1;
        step(1);
        bus.rtx_ack = 0; dup_det = 0;
        step(1);
        dup_det = 1;
        cnt = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (bus.rtx_req) cnt++;
            #1;
        end
        chk("t4_lock", cnt, 0);

        // 5: disconnect withdraws a pending request
        found = 0;
        for (int k = 1; k <= 40 && !found; k++) begin
            @(negedge clk);
            if (bus.rtx_req) found = 1;
            #1;
        end
        chk("t5_req_seen", found, 1);
        step(2);
        connected = 0;
        @(negedge clk);
        chk("t5_req", bus.rtx_req, 0);
        chk("t5_backoff", backoff, 0);
        #1;

        // 6: nothing outstanding, then reset mid-request
        do_reset();
        connected = 1; loc_seq = 200; rem_ack = 200;
        cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.rtx_req) cnt++;
            #1;
            dup_det = k[1];
        end
        chk("t6_noreq", cnt, 0);
        loc_seq = 300; dup_det = 0;
        step(2);
        dup_det = 1; dup_ack = 250;
        @(negedge clk);
        chk("t6_req", bus.rtx_req, 1);
        chk("t6_seq", bus.rtx_seq, 250);
        #1;
        rst = 1;
        @(negedge clk);
        chk("t6_rst_req", bus.rtx_req, 0);
        chk("t6_rst_seq", bus.rtx_seq, 0);
        chk("t6_rst_fast", bus.rtx_fast, 0);
        chk("t6_rst_bo", backoff, 0);
        chk("t6_rst_abort", abort, 0);
        #1;
        rst = 0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
